adc_serial_multich: RTL
=======================

// Module: adc_serial_multich
// PURPOSE
//  Next-generation serial-ADC sampler for ADS7822-class converters. NCH converters share one
//  ad_clk/ad_cs pair, each with its own dout line, and are read simultaneously. Conversions start
//  on an external trigger edge or from an internal free-running timer. Sits between the ADC pins
//  and the power-unit control logic; delivers packed parallel samples with a 1-cycle valid strobe.
// PARAMETERS
//  CLK_DIV    40  clk cycles per ad_clk period; even, >=8 (40 MHz/40 = 1 MHz)
//  DATA_W     12  result bits per channel, MSB first
//  LEAD_BITS  3   ad_clk periods after CS setup before MSB (2 sample + 1 null bit)
//  NCH        4   parallel converters / dout lines
//  SAMPLE_DLY 3   clk cycles after ad_clk rise at which dout is captured; < CLK_DIV/2
//  CSH_CYC    20  minimum ad_cs-high clk cycles between conversions
//  AVG_LOG2   2   averaging depth 2^AVG_LOG2 (used only with ADC_AVG_EN)
// PORTS
//  clk          in   1          system clock, 40 MHz
//  rst_n        in   1          async active-low reset
//  enable       in   1          block enable; low aborts any conversion
//  trigger      in   1          async; rising edge requests one conversion
//  auto_en      in   1          1 = internal timer triggers
//  conv_period  in   16         timer period in clk cycles; 0 = no timer triggers
//  ad_dout      in   NCH        serial data from converters
//  ad_clk       out  1          ADC serial clock
//  ad_cs        out  1          ADC chip select, active low
//  sample_data  out  NCH*DATA_W packed results, ch0 in [DATA_W-1:0]
//  data_valid   out  1          1-cycle strobe, sample_data updated same cycle
//  busy         out  1          high from CS fall to end of CS-high hold
//  trig_miss    out  1          1-cycle pulse: trigger arrived while busy, dropped
// BEHAVIOUR
//  Reset: ad_cs=1, ad_clk=0, sample_data=0, data_valid=0, busy=0, trig_miss=0, state IDLE.
//  trigger and ad_dout each double-flop synchronised; request = sync rising edge OR timer tick.
//  Timer: counter free-runs 0..conv_period-1 while auto_en&&enable, ticks at wrap; cleared otherwise.
//  FSM IDLE->SETUP->SHIFT->HOLD->IDLE:
//   IDLE: request&&enable -> SETUP next cycle (ad_cs falls). Request while busy -> trig_miss.
//   SETUP: ad_cs=0, ad_clk=0 for CLK_DIV cycles.
//   SHIFT: LEAD_BITS+DATA_W periods; div_cnt 0..CLK_DIV-1; ad_clk=1 when div_cnt>=CLK_DIV/2.
//    Bits with index>=LEAD_BITS: at div_cnt==CLK_DIV/2+SAMPLE_DLY shift synced dout[i] into sreg[i] LSB.
//   Last period end: sample_data<=all sreg, data_valid=1, ad_cs rises, ad_clk=0 -> HOLD.
//   HOLD: CSH_CYC cycles, busy=1, requests dropped with trig_miss -> IDLE.
//  Latency: CS fall to data_valid = CLK_DIV*(1+LEAD_BITS+DATA_W) = 640 cycles at defaults.
//  Simultaneous request and data_valid: request is in HOLD, dropped.
//  enable low in any non-IDLE state: next cycle IDLE, ad_cs=1, ad_clk=0, no data_valid,
//   sample_data unchanged, shift regs cleared.
//  Reset mid-conversion: immediate return to reset values.
// CONFIGURATION
//  ADC_AVG_EN defined: per-channel accumulators, DATA_W+AVG_LOG2 bits. Each conversion adds the result.
//   data_valid fires only on every 2^AVG_LOG2-th conversion, with sample_data = acc>>AVG_LOG2
//   (truncated); then accumulators clear. Abort or enable low also clears accumulators and count.
//  ADC_AVG_EN undefined: no accumulators; every conversion drives data_valid.
// STRUCTURE
//  Package adc_serial_pkg: FSM state encoding and localparam NBITS=LEAD_BITS+DATA_W.
//  One sub-module, adc_sclk_gen, contains div_cnt, bit counter, ad_clk generation and a
//  sample-strike strobe. The top holds the FSM, sync flops, timer, shift regs and averaging.
// TESTING
//  1 Defaults, NCH=2, models return 12'hA5C/12'h3F1, trigger 0->1 -> sample_data={12'h3F1,12'hA5C},
//    data_valid 640 cycles after ad_cs fall, 15 ad_clk rises, 1 MHz.
//  2 auto_en=1, conv_period=1000 -> data_valid every 1000 cycles, trig_miss never.
//  3 auto_en=1, conv_period=500 -> one conversion per 1000 cycles, trig_miss every 1000 cycles.
//  4 enable low during SHIFT bit 5 -> ad_cs=1 next cycle, no data_valid, sample_data held;
//    next trigger converts correctly.
//  5 ADC_AVG_EN, AVG_LOG2=2, ch0 returns 100,101,102,104 -> one data_valid, ch0=101.
//  6 rst_n low mid-SHIFT -> ad_cs=1, ad_clk=0, outputs zero asynchronously.

Source files
------------

// File: rtl/adc_serial_pkg.sv
// Shared FSM encoding and default geometry for the multichannel serial ADC sampler.
// ADC_AVG_EN adds the averaging depth default.
package adc_serial_pkg;

    localparam int unsigned CLK_DIV_DEF    = 40;
    localparam int unsigned DATA_W_DEF     = 12;
    localparam int unsigned LEAD_BITS_DEF  = 3;
    localparam int unsigned NCH_DEF        = 4;
    localparam int unsigned SAMPLE_DLY_DEF = 3;
    localparam int unsigned CSH_CYC_DEF    = 20;
    localparam int unsigned NBITS          = LEAD_BITS_DEF + DATA_W_DEF;
`ifdef ADC_AVG_EN
    localparam int unsigned AVG_LOG2_DEF   = 2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock generator: divider, bit counter, registered ad_clk and the dout sample strike.
module adc_sclk_gen
    import adc_serial_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
    parameter int unsigned NB         = NBITS,
    parameter int unsigned LEAD_BITS  = LEAD_BITS_DEF,
    parameter int unsigned SAMPLE_DLY = SAMPLE_DLY_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic shift,
    output logic ad_clk,
    output logic period_end_c,
    output logic last_c,
    output logic strike_c
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = $clog2(NB + 1);
    localparam int unsigned HALF  = CLK_DIV / 2;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             ad_clk_q, ad_clk_d;

    always_comb begin
        period_end_c = run && (div_cnt_q == DIV_W'(CLK_DIV - 1));
        last_c       = shift && period_end_c && (bit_cnt_q == BIT_W'(NB - 1));
        strike_c     = shift && (div_cnt_q == DIV_W'(HALF + SAMPLE_DLY))
                       && (bit_cnt_q >= BIT_W'(LEAD_BITS));

        div_cnt_d = '0;
        if (run && !period_end_c) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        bit_cnt_d = '0;
        if (shift) begin
            bit_cnt_d = period_end_c ? bit_cnt_q + BIT_W'(1) : bit_cnt_q;
        end

        // ad_clk follows the next divider value so the pin is high exactly while div_cnt >= HALF
        ad_clk_d = shift && (div_cnt_d >= DIV_W'(HALF));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            ad_clk_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            ad_clk_q  <= ad_clk_d;
        end
    end

    assign ad_clk = ad_clk_q;

endmodule

// File: rtl/adc_serial_multich.sv
// Multichannel ADS7822-style sampler: shared ad_clk/ad_cs, per-channel dout, trigger or timer start.
// ADC_AVG_EN enables per-channel averaging over 2^AVG_LOG2 conversions.
module adc_serial_multich
    import adc_serial_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned LEAD_BITS  = LEAD_BITS_DEF,
    parameter int unsigned NCH        = NCH_DEF,
    parameter int unsigned SAMPLE_DLY = SAMPLE_DLY_DEF,
    parameter int unsigned CSH_CYC    = CSH_CYC_DEF
`ifdef ADC_AVG_EN
    ,
    parameter int unsigned AVG_LOG2   = AVG_LOG2_DEF
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  trigger,
    input  logic                  auto_en,
    input  logic [15:0]           conv_period,
    input  logic [NCH-1:0]        ad_dout,
    output logic                  ad_clk,
    output logic                  ad_cs,
    output logic [NCH*DATA_W-1:0] sample_data,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  trig_miss
);

    localparam int unsigned HOLD_W = $clog2(CSH_CYC + 1);

    state_e                       state_q, state_d;
    logic [2:0]                   trig_sync_q, trig_sync_d;
    logic [NCH-1:0]               dout_s1_q, dout_s1_d, dout_s2_q, dout_s2_d;
    logic [15:0]                  tmr_q, tmr_d;
    logic [HOLD_W-1:0]            hold_q, hold_d;
    logic [NCH-1:0][DATA_W-1:0]   sreg_q, sreg_d;
    logic [NCH-1:0][DATA_W-1:0]   sample_data_q, sample_data_d;
    logic                         ad_cs_q, ad_cs_d;
    logic                         data_valid_q, data_valid_d;
    logic                         busy_q, busy_d;
    logic                         trig_miss_q, trig_miss_d;
    logic                         tmr_on_c, tick_c, req_c, run_c, shift_c;
    logic                         period_end_c, last_c, strike_c;
`ifdef ADC_AVG_EN
    localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
    localparam int unsigned AVG_N = 1 << AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    logic [NCH-1:0][ACC_W-1:0]    acc_q, acc_d, sum_c;
    logic [CNT_W-1:0]             avg_cnt_q, avg_cnt_d;
`endif

    assign run_c   = enable && (state_q == ST_SETUP || state_q == ST_SHIFT);
    assign shift_c = enable && (state_q == ST_SHIFT);

    adc_sclk_gen #(
        .CLK_DIV    (CLK_DIV),
        .NB         (LEAD_BITS + DATA_W),
        .LEAD_BITS  (LEAD_BITS),
        .SAMPLE_DLY (SAMPLE_DLY)
    ) u_sclk (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run_c),
        .shift        (shift_c),
        .ad_clk       (ad_clk),
        .period_end_c (period_end_c),
        .last_c       (last_c),
        .strike_c     (strike_c)
    );

    always_comb begin
        trig_sync_d = {trig_sync_q[1:0], trigger};
        dout_s1_d   = ad_dout;
        dout_s2_d   = dout_s1_q;

        tmr_on_c = auto_en && enable && (conv_period != 16'd0);
        tick_c   = tmr_on_c && (tmr_q >= conv_period - 16'd1);
        tmr_d    = (!tmr_on_c || tick_c) ? 16'd0 : tmr_q + 16'd1;
        req_c    = (trig_sync_q[1] && !trig_sync_q[2]) || tick_c;

        state_d = state_q;
        hold_d  = '0;
        case (state_q)
            ST_IDLE:  if (req_c) state_d = ST_SETUP;
            ST_SETUP: if (period_end_c) state_d = ST_SHIFT;
            ST_SHIFT: if (last_c) state_d = ST_HOLD;
            ST_HOLD: begin
                hold_d = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_W'(CSH_CYC - 1)) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
        if (!enable) state_d = ST_IDLE;

        busy_d      = (state_d != ST_IDLE);
        ad_cs_d     = !(state_d == ST_SETUP || state_d == ST_SHIFT);
        trig_miss_d = req_c && enable && (state_q != ST_IDLE);

        sreg_d = sreg_q;
        if (!run_c) begin
            sreg_d = '0;
        end else if (strike_c) begin
            for (int i = 0; i < NCH; i++) begin
                sreg_d[i] = {sreg_q[i][DATA_W-2:0], dout_s2_q[i]};
            end
        end

        data_valid_d  = 1'b0;
        sample_data_d = sample_data_q;
`ifdef ADC_AVG_EN
        acc_d     = acc_q;
        avg_cnt_d = avg_cnt_q;
        for (int i = 0; i < NCH; i++) begin
            sum_c[i] = acc_q[i] + ACC_W'(sreg_q[i]);
        end
        if (!enable) begin
            acc_d     = '0;
            avg_cnt_d = '0;
        end else if (last_c) begin
            if (avg_cnt_q == CNT_W'(AVG_N - 1)) begin
                data_valid_d = 1'b1;
                for (int i = 0; i < NCH; i++) begin
                    sample_data_d[i] = DATA_W'(sum_c[i] >> AVG_LOG2);
                end
                acc_d     = '0;
                avg_cnt_d = '0;
            end else begin
                acc_d     = sum_c;
                avg_cnt_d = avg_cnt_q + CNT_W'(1);
            end
        end
`else
        if (last_c) begin
            data_valid_d  = 1'b1;
            sample_data_d = sreg_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            trig_sync_q   <= '0;
            dout_s1_q     <= '0;
            dout_s2_q     <= '0;
            tmr_q         <= '0;
            hold_q        <= '0;
            sreg_q        <= '0;
            sample_data_q <= '0;
            ad_cs_q       <= 1'b1;
            data_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            trig_miss_q   <= 1'b0;
`ifdef ADC_AVG_EN
            acc_q         <= '0;
            avg_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            trig_sync_q   <= trig_sync_d;
            dout_s1_q     <= dout_s1_d;
            dout_s2_q     <= dout_s2_d;
            tmr_q         <= tmr_d;
            hold_q        <= hold_d;
            sreg_q        <= sreg_d;
            sample_data_q <= sample_data_d;
            ad_cs_q       <= ad_cs_d;
            data_valid_q  <= data_valid_d;
            busy_q        <= busy_d;
            trig_miss_q   <= trig_miss_d;
`ifdef ADC_AVG_EN
            acc_q         <= acc_d;
            avg_cnt_q     <= avg_cnt_d;
`endif
        end
    end

    assign ad_cs       = ad_cs_q;
    assign sample_data = sample_data_q;
    assign data_valid  = data_valid_q;
    assign busy        = busy_q;
    assign trig_miss   = trig_miss_q;

endmodule
